// File: rtl/npu_pkg.sv
// Shared NPU package: read-side FSM state encoding and the 1-bit
// round-robin arbitration pointer used by fram_arbiter.
`include "defines.sv"

package npu_pkg;

  localparam int FRAM_ADDR_W = `FRAM_ADDR_WIDTH;
  localparam int FRAM_BANK_W = $clog2(`FRAM_BANK_NUM);
  localparam int FRAM_DATA_W = `DATA_WIDTH;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RSP  = 1'b1
  } rd_state_e;

  // Side that wins the next same-bank collision.
  typedef enum logic {
    PTR_RD = 1'b0,
    PTR_WR = 1'b1
  } arb_ptr_e;

endpackage

// File: rtl/defines.sv
// Build-wide width macros for the FRAM subsystem.
// Guarded so it may be both compiled on its own and included by any file.
`ifndef FRAM_DEFINES_SV
`define FRAM_DEFINES_SV
`define FRAM_ADDR_WIDTH 12
`define FRAM_BANK_NUM   4
`define DATA_WIDTH      16
`endif

// File: rtl/fram_wbuf.sv
// Two-entry in-order write buffer (address + data).
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   push/push_addr/data   enqueue (ignored when full)
//   pop                   dequeue head (ignored when empty)
//   head_addr/head_data   current head entry
//   empty, full           occupancy flags
module fram_wbuf #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              empty,
  output logic              full
);

  logic [ADDR_W-1:0] addr_mem [2];
  logic [DATA_W-1:0] data_mem [2];
  logic              wr_idx;
  logic              rd_idx;
  logic [1:0]        count;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign head_addr = addr_mem[rd_idx];
  assign head_data = data_mem[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) wr_idx <= ~wr_idx;
      if (pop_ok)  rd_idx <= ~rd_idx;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_mem[wr_idx] <= push_addr;
      data_mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/fram_arbiter.sv
// FRAM read/write arbiter in front of a banked router.
// One read port (1-cycle latency) and one buffered write port share the
// banks; different-bank requests issue together, same-bank collisions are
// resolved by a 1-bit round-robin pointer.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   rd_req_valid/ready/addr            read request handshake
//   rd_rsp_valid/data                  read response (cycle after grant)
//   wr_req_valid/ready/addr/data       write request handshake
//   rp_addr, rp_rdata                  router read port
//   wp_addr, wp_wdata, wp_en           router write port
//   wbuf_empty                         every accepted write has issued
`include "defines.sv"

module fram_arbiter
  import npu_pkg::*;
#(
  parameter int ADDR_W = `FRAM_ADDR_WIDTH,
  parameter int BANK_W = $clog2(`FRAM_BANK_NUM),
  parameter int DATA_W = `DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_rsp_valid,
  output logic [DATA_W-1:0] rd_rsp_data,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_data,
  output logic [ADDR_W-1:0] rp_addr,
  input  logic [DATA_W-1:0] rp_rdata,
  output logic [ADDR_W-1:0] wp_addr,
  output logic [DATA_W-1:0] wp_wdata,
  output logic              wp_en,
  output logic              wbuf_empty
);

  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_push;

  logic [BANK_W-1:0] rd_bank;
  logic [BANK_W-1:0] wr_bank;
  logic [BANK_W-1:0] last_bank;
  logic [BANK_W-1:0] rp_bank;

  logic              rd_cand;
  logic              wr_cand;
  logic              collide;
  logic              rd_gnt;
  logic              wr_gnt;

  rd_state_e         rd_state;
  rd_state_e         rd_state_nxt;
  arb_ptr_e          ptr;
  arb_ptr_e          ptr_nxt;
  logic [ADDR_W-1:0] rd_addr_p1;

  assign wr_req_ready = rst_n && !fifo_full;
  assign fifo_push    = wr_req_valid && wr_req_ready;

  fram_wbuf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_wbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_addr (wr_req_addr),
    .push_data (wr_req_data),
    .pop       (wr_gnt),
    .head_addr (head_addr),
    .head_data (head_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign rd_bank   = rd_req_addr[ADDR_W-1 -: BANK_W];
  assign wr_bank   = head_addr[ADDR_W-1 -: BANK_W];
  assign last_bank = rd_addr_p1[ADDR_W-1 -: BANK_W];

  // Arbitration and read FSM next state. While a response is in flight the
  // router keeps the previous read bank selected, so only a same-bank read
  // may follow immediately; any other bank waits for R_IDLE.
  always_comb begin
    rd_cand      = 1'b0;
    wr_cand      = 1'b0;
    collide      = 1'b0;
    rd_gnt       = 1'b0;
    wr_gnt       = 1'b0;
    ptr_nxt      = ptr;
    rd_state_nxt = R_IDLE;

    rd_cand = rst_n && rd_req_valid &&
              ((rd_state == R_IDLE) || (rd_bank == last_bank));
    wr_cand = rst_n && !fifo_empty;
    collide = rd_cand && wr_cand && (rd_bank == wr_bank);

    rd_gnt = rd_cand && (!collide || (ptr == PTR_RD));
    wr_gnt = wr_cand && (!collide || (ptr == PTR_WR));

    if (collide) ptr_nxt = (ptr == PTR_RD) ? PTR_WR : PTR_RD;

    if (rd_gnt) rd_state_nxt = R_RSP;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state   <= R_IDLE;
      ptr        <= PTR_RD;
      rd_addr_p1 <= '0;
    end else begin
      rd_state <= rd_state_nxt;
      ptr      <= ptr_nxt;
      if (rd_gnt) rd_addr_p1 <= rd_req_addr;
    end
  end

  // Grant stage: router address is live on a grant, otherwise held.
  assign rd_req_ready = rd_gnt;
  assign rp_addr      = rd_gnt ? rd_req_addr : rd_addr_p1;
  assign rp_bank      = rp_addr[ADDR_W-1 -: BANK_W];

  // An idle write port points at a bank the read port is not using, so the
  // router never blocks the read bank on behalf of a non-write.
  assign wp_en    = wr_gnt;
  assign wp_addr  = wr_gnt ? head_addr
                           : {rp_bank ^ BANK_W'(1), {(ADDR_W-BANK_W){1'b0}}};
  assign wp_wdata = wr_gnt ? head_data : '0;

  // Response stage: rp_rdata now holds the word addressed in the grant cycle.
  assign rd_rsp_valid = rst_n && (rd_state == R_RSP);
  assign rd_rsp_data  = rd_rsp_valid ? rp_rdata : '0;

  assign wbuf_empty = fifo_empty;

endmodule

// File: tb/tb_fram_arbiter.sv
module tb_fram_arbiter;

  localparam int ADDR_W = 12;
  localparam int BANK_W = 2;
  localparam int DATA_W = 16;

  logic              clk;
  logic              rst_n;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              rd_rsp_valid;
  logic [DATA_W-1:0] rd_rsp_data;
  logic              wr_req_valid;
  logic              wr_req_ready;
  logic [ADDR_W-1:0] wr_req_addr;
  logic [DATA_W-1:0] wr_req_data;
  logic [ADDR_W-1:0] rp_addr;
  logic [DATA_W-1:0] rp_rdata;
  logic [ADDR_W-1:0] wp_addr;
  logic [DATA_W-1:0] wp_wdata;
  logic              wp_en;
  logic              wbuf_empty;

  int n_cmp;
  int n_fail;

  logic [DATA_W-1:0]        rd_exp[$];
  logic [ADDR_W+DATA_W-1:0] wr_exp[$];
  logic [DATA_W-1:0]        mem[int];

  fram_arbiter #(
    .ADDR_W (ADDR_W),
    .BANK_W (BANK_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_data  (rd_rsp_data),
    .wr_req_valid (wr_req_valid),
    .wr_req_ready (wr_req_ready),
    .wr_req_addr  (wr_req_addr),
    .wr_req_data  (wr_req_data),
    .rp_addr      (rp_addr),
    .rp_rdata     (rp_rdata),
    .wp_addr      (wp_addr),
    .wp_wdata     (wp_wdata),
    .wp_en        (wp_en),
    .wbuf_empty   (wbuf_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous BRAM behind the router; unwritten words read as 0xA000|addr.
  always @(posedge clk) begin
    rp_rdata <= mem.exists(int'(rp_addr)) ? mem[int'(rp_addr)]
                                          : (16'hA000 | 16'(rp_addr));
    if (wp_en) mem[int'(wp_addr)] = wp_wdata;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] idle_wp(input logic [ADDR_W-1:0] a);
    return {a[11:10] ^ 2'b01, 10'b0};
  endfunction

  task automatic monitor();
    logic [DATA_W-1:0]        e;
    logic [ADDR_W+DATA_W-1:0] w;
    forever begin
      @(negedge clk);
      if (rd_rsp_valid) begin
        if (rd_exp.size() == 0) chk("rd_rsp_unexpected", 32'(rd_rsp_data), 32'hFFFF_FFFF);
        else begin
          e = rd_exp.pop_front();
          chk("rd_rsp_data", 32'(rd_rsp_data), 32'(e));
        end
      end
      if (wp_en) begin
        if (wr_exp.size() == 0) chk("wr_issue_unexpected", 32'({wp_addr, wp_wdata}), 32'hFFFF_FFFF);
        else begin
          w = wr_exp.pop_front();
          chk("wr_issue", 32'({wp_addr, wp_wdata}), 32'(w));
        end
        if (rd_req_ready)
          chk("same_bank_rd_wr", 32'(rp_addr[11:10] == wp_addr[11:10]), 32'd0);
      end else begin
        chk("idle_wp_addr", 32'(wp_addr), 32'(idle_wp(rp_addr)));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rv, input logic [11:0] ra,
                       input logic wv, input logic [11:0] wa, input logic [15:0] wd);
    rd_req_valid = rv;
    rd_req_addr  = ra;
    wr_req_valid = wv;
    wr_req_addr  = wa;
    wr_req_data  = wd;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    drive(1'b1, 12'h123, 1'b1, 12'h456, 16'h7777);
    fork monitor(); join_none

    // Reset state, with requests pending
    tick();
    @(negedge clk);
    chk("rst_rd_ready", 32'(rd_req_ready), 0);
    chk("rst_wr_ready", 32'(wr_req_ready), 0);
    chk("rst_wbuf_empty", 32'(wbuf_empty), 1);
    chk("rst_rsp_valid", 32'(rd_rsp_valid), 0);
    chk("rst_rsp_data", 32'(rd_rsp_data), 0);
    chk("rst_wp_en", 32'(wp_en), 0);
    chk("rst_wp_wdata", 32'(wp_wdata), 0);
    chk("rst_rp_addr", 32'(rp_addr), 0);
    chk("rst_wp_addr", 32'(wp_addr), 32'h400);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 12'h0, 1'b0, 12'h0, 16'h0);
    tick();

    // Disjoint banks: read 0x010 alongside write 0x810
    drive(1'b0, 12'h000, 1'b1, 12'h810, 16'h00AB);
    @(negedge clk);
    chk("t1_wr_ready", 32'(wr_req_ready), 1);
    wr_exp.push_back({12'h810, 16'h00AB});
    tick();
    drive(1'b1, 12'h010, 1'b0, 12'h000, 16'h0);
    @(negedge clk);
    chk("t1_rd_ready", 32'(rd_req_ready), 1);
    chk("t1_wp_en", 32'(wp_en), 1);
    chk("t1_wp_addr", 32'(wp_addr), 32'h810);
    rd_exp.push_back(16'hA010);
    tick();
    drive(1'b0, 12'h000, 1'b0, 12'h000, 16'h0);
    @(negedge clk);
    chk("t1_rsp_valid", 32'(rd_rsp_valid), 1);
    chk("t1_wbuf_empty", 32'(wbuf_empty), 1);
    tick();

    // Same-bank collision: read first, write next, pointer back to read
    drive(1'b0, 12'h000, 1'b1, 12'h401, 16'h1234);
    @(negedge clk);
    wr_exp.push_back({12'h401, 16'h1234});
    tick();
    drive(1'b1, 12'h400, 1'b0, 12'h000, 16'h0);
    @(negedge clk);
    chk("t2_rd_first", 32'(rd_req_ready), 1);
    chk("t2_wr_waits", 32'(wp_en), 0);
    rd_exp.push_back(16'hA400);
    tick();
    drive(1'b1, 12'h404, 1'b0, 12'h000, 16'h0);
    @(negedge clk);
    chk("t2_rd_loses", 32'(rd_req_ready), 0);
    chk("t2_wr_second", 32'(wp_en), 1);
    chk("t2_rsp_valid", 32'(rd_rsp_valid), 1);
    tick();
    @(negedge clk);
    chk("t2_rd_retry", 32'(rd_req_ready), 1);
    chk("t2_rsp_gap", 32'(rd_rsp_valid), 0);
    rd_exp.push_back(16'hA404);
    tick();
    drive(1'b0, 12'h000, 1'b0, 12'h000, 16'h0);
    @(negedge clk);
    chk("t2_rsp2_valid", 32'(rd_rsp_valid), 1);
    tick();

    // Back-to-back same-bank reads
    drive(1'b1, 12'h020, 1'b0, 12'h000, 16'h0);
    @(negedge clk);
    rd_exp.push_back(16'hA020);
    tick();
    drive(1'b1, 12'h021, 1'b0, 12'h000, 16'h0);
    @(negedge clk);
    chk("t3_b2b_ready", 32'(rd_req_ready), 1);
    chk("t3_b2b_rsp1", 32'(rd_rsp_valid), 1);
    rd_exp.push_back(16'hA021);
    tick();
    drive(1'b0, 12'h000, 1'b0, 12'h000, 16'h0);
    @(negedge clk);
    chk("t3_b2b_rsp2", 32'(rd_rsp_valid), 1);
    tick();
    // Bank change costs one bubble
    drive(1'b1, 12'h020, 1'b0, 12'h000, 16'h0);
    @(negedge clk);
    rd_exp.push_back(16'hA020);
    tick();
    drive(1'b1, 12'h820, 1'b0, 12'h000, 16'h0);
    @(negedge clk);
    chk("t3_bubble_ready", 32'(rd_req_ready), 0);
    chk("t3_bubble_rsp", 32'(rd_rsp_valid), 1);
    chk("t3_hold_bank", 32'(rp_addr), 32'h020);
    tick();
    @(negedge clk);
    chk("t3_after_bubble", 32'(rd_req_ready), 1);
    chk("t3_no_rsp", 32'(rd_rsp_valid), 0);
    rd_exp.push_back(16'hA820);
    tick();
    drive(1'b0, 12'h000, 1'b0, 12'h000, 16'h0);
    @(negedge clk);
    chk("t3_rsp_2apart", 32'(rd_rsp_valid), 1);
    tick();

    // FIFO full under a colliding read stream
    drive(1'b1, 12'h104, 1'b1, 12'h100, 16'h0001);
    @(negedge clk);
    chk("t4_c1_wr_ready", 32'(wr_req_ready), 1);
    chk("t4_c1_rd_ready", 32'(rd_req_ready), 1);
    rd_exp.push_back(16'hA104);
    wr_exp.push_back({12'h100, 16'h0001});
    tick();
    drive(1'b1, 12'h105, 1'b1, 12'h101, 16'h0002);
    @(negedge clk);
    chk("t4_c2_wr_ready", 32'(wr_req_ready), 1);
    chk("t4_c2_rd_wins", 32'(rd_req_ready), 1);
    chk("t4_c2_wp_en", 32'(wp_en), 0);
    rd_exp.push_back(16'hA105);
    wr_exp.push_back({12'h101, 16'h0002});
    tick();
    drive(1'b1, 12'h106, 1'b1, 12'h102, 16'h0003);
    @(negedge clk);
    chk("t4_c3_full", 32'(wr_req_ready), 0);
    chk("t4_c3_rd_loses", 32'(rd_req_ready), 0);
    chk("t4_c3_wp_en", 32'(wp_en), 1);
    tick();
    @(negedge clk);
    chk("t4_c4_wr_ready", 32'(wr_req_ready), 1);
    chk("t4_c4_rd_wins", 32'(rd_req_ready), 1);
    chk("t4_c4_wp_en", 32'(wp_en), 0);
    rd_exp.push_back(16'hA106);
    wr_exp.push_back({12'h102, 16'h0003});
    tick();
    drive(1'b0, 12'h000, 1'b0, 12'h000, 16'h0);
    @(negedge clk);
    chk("t4_c5_wp_en", 32'(wp_en), 1);
    chk("t4_c5_full", 32'(wr_req_ready), 0);
    tick();
    @(negedge clk);
    chk("t4_c6_wp_en", 32'(wp_en), 1);
    tick();
    @(negedge clk);
    chk("t4_drained", 32'(wbuf_empty), 1);
    chk("t4_c7_wp_en", 32'(wp_en), 0);
    tick();

    // Idle write port steers away from read bank 3
    drive(1'b1, 12'hC00, 1'b0, 12'h000, 16'h0);
    @(negedge clk);
    chk("t5_rp_addr", 32'(rp_addr), 32'hC00);
    chk("t5_wp_addr", 32'(wp_addr), 32'h800);
    rd_exp.push_back(16'hAC00);
    tick();
    drive(1'b0, 12'h000, 1'b0, 12'h000, 16'h0);
    @(negedge clk);
    chk("t5_wp_addr_rsp", 32'(wp_addr), 32'h800);
    tick();
    @(negedge clk);
    chk("t5_rp_hold", 32'(rp_addr), 32'hC00);
    tick();

    // Reset right after a read grant with two writes buffered
    drive(1'b0, 12'h000, 1'b1, 12'hC01, 16'h0A0A);
    @(negedge clk);
    wr_exp.push_back({12'hC01, 16'h0A0A});
    tick();
    drive(1'b1, 12'hC03, 1'b1, 12'hC02, 16'h0B0B);
    @(negedge clk);
    chk("t6_wr_wins", 32'(wp_en), 1);
    tick();
    drive(1'b1, 12'hC03, 1'b1, 12'hC04, 16'h0C0C);
    @(negedge clk);
    chk("t6_rd_gnt", 32'(rd_req_ready), 1);
    chk("t6_two_buffered", 32'(wbuf_empty), 0);
    tick();
    rst_n = 1'b0;
    drive(1'b1, 12'hC03, 1'b1, 12'hC05, 16'h0D0D);
    @(negedge clk);
    chk("t6_rst_rsp", 32'(rd_rsp_valid), 0);
    chk("t6_rst_wp_en", 32'(wp_en), 0);
    chk("t6_rst_rd_ready", 32'(rd_req_ready), 0);
    chk("t6_rst_wr_ready", 32'(wr_req_ready), 0);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 12'h000, 1'b0, 12'h000, 16'h0);
    @(negedge clk);
    chk("t6_post_empty", 32'(wbuf_empty), 1);
    chk("t6_post_rsp", 32'(rd_rsp_valid), 0);
    chk("t6_post_wp_en", 32'(wp_en), 0);
    chk("t6_post_rp_addr", 32'(rp_addr), 0);
    tick();
    @(negedge clk);
    chk("t6_post2_rsp", 32'(rd_rsp_valid), 0);
    chk("t6_post2_empty", 32'(wbuf_empty), 1);

    chk("rd_queue_drained", 32'(rd_exp.size()), 0);
    chk("wr_queue_drained", 32'(wr_exp.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fram_arbiter.md
FRAM_ARBITER -- requirements
Module: fram_arbiter

Interface
REQ-001 SHALL take parameters, one per line: name, default, meaning.
- ADDR_W, `FRAM_ADDR_WIDTH, FRAM word address width.
- BANK_W, $clog2(`FRAM_BANK_NUM), bank-select width; these are the top address bits.
- DATA_W, `DATA_WIDTH, data word width.
REQ-002 SHALL have ports, one per line: name direction width meaning.
- clk in 1: single clock.
- rst_n in 1: synchronous, active-low reset.
- rd_req_valid in 1, rd_req_ready out 1, rd_req_addr in ADDR_W: read request handshake.
- rd_rsp_valid out 1, rd_rsp_data out DATA_W: read response.
- wr_req_valid in 1, wr_req_ready out 1, wr_req_addr in ADDR_W, wr_req_data in DATA_W: write request handshake.
- rp_addr out ADDR_W, rp_rdata in DATA_W: router read port.
- wp_addr out ADDR_W, wp_wdata out DATA_W, wp_en out 1: router write port.
- wbuf_empty out 1: all accepted writes have been issued.
REQ-003 SHALL use one clock; reset is synchronous and active-low (clk, rst_n).

Function
REQ-004 SHALL accept a request on a port only on a rising clk edge where that port's valid and ready are both high.
REQ-005 SHALL buffer accepted writes in a 2-entry in-order FIFO.
- wr_req_ready = FIFO not full.
- A push and a pop in the same cycle while the FIFO is full SHALL NOT be accepted; ready stays low.
REQ-006 SHALL issue a write candidate from the FIFO head when the FIFO is not empty.
REQ-007 SHALL treat a read request as a candidate when rd_req_valid is high.
- rd_req_ready is combinational and is high only in a cycle where the read is granted.
REQ-008 SHALL grant both candidates in the same cycle when their bank bits differ.
REQ-009 SHALL resolve a same-bank collision with a 1-bit round-robin pointer.
- Pointer reset value = read priority.
- After each collision the pointer moves to the losing side.
- No collision leaves the pointer unchanged.
REQ-010 SHALL drive wp_en=1, wp_addr and wp_wdata from the FIFO head combinationally in a write-grant cycle, and pop the head at that edge.
REQ-011 SHALL drive wp_addr with the rp_addr bank bits XOR 1 and the remaining bits zero whenever wp_en=0, so the router never masks a read bank.
REQ-012 SHALL present read data with one-cycle latency.
- rd_rsp_valid is registered and is high exactly in the cycle after a read grant.
- rd_rsp_data = rp_rdata in that cycle.
REQ-013 SHALL keep rp_addr bank bits equal to the previous read's bank during the response cycle.
REQ-014 SHALL allow a new read grant in a response cycle only when its bank equals the previous read's bank; otherwise the read waits one bubble cycle.
REQ-015 SHALL implement the read-side FSM:
- R_IDLE -> R_RSP on a read grant.
- R_RSP -> R_RSP on a same-bank read grant.
- R_RSP -> R_IDLE otherwise.
REQ-016 SHALL permit write grants in any read-FSM state, subject only to REQ-008 and REQ-009.
REQ-017 SHALL hold rp_addr at its last value when no read is granted in R_IDLE.
REQ-018 SHALL drive wbuf_empty = FIFO empty, as a combinational output.
REQ-019 SHALL never issue a read and a write to the same bank in one cycle.

Reset
REQ-020 SHALL, on rst_n=0 sampled at a clk edge, apply these reset values:
- FIFO empty; all accepted writes are discarded.
- Read FSM = R_IDLE; pointer = read priority.
- rd_rsp_valid=0, rd_rsp_data=0, wp_en=0, wp_wdata=0, rp_addr=0, wbuf_empty=1.
REQ-021 SHALL suppress a response pending from a read granted in the cycle before reset; rd_rsp_valid stays 0.
REQ-022 SHALL hold rd_req_ready=0 and wr_req_ready=0 while rst_n=0.

Structure
REQ-023 SHALL place the read-FSM state enum and the arbitration-pointer typedef in the shared package npu_pkg; widths come from defines.sv macros.
REQ-024 SHALL implement the write FIFO as sub-module fram_wbuf, parameterised by DATA_W and ADDR_W, depth 2.

Verification (bench configuration: `FRAM_BANK_NUM=4, ADDR_W=12, bank = addr[11:10])
REQ-025 Disjoint banks: read 0x010 and write 0x810/0xAB in the same cycle -> both granted.
- wp_en=1 and wp_addr=0x810 in that cycle.
- rd_rsp_valid high the next cycle, with the BRAM content of 0x010.
REQ-026 Collision after reset: read 0x400 and write 0x401 both pending, FIFO otherwise empty.
- Read is granted first; the write is granted the next cycle; the pointer returns to read priority.
REQ-027 Back-to-back reads to 0x020, 0x021 (same bank) -> rd_rsp_valid high for 2 consecutive cycles.
- Reads to 0x020 then 0x820 -> one bubble; the responses are 2 cycles apart.
REQ-028 FIFO full: 3 writes presented on consecutive cycles while a read stream collides with the same bank.
- wr_req_ready drops after 2 acceptances.
- Writes are issued in order; wbuf_empty returns to 1.
REQ-029 Idle read port: wp_en=0 with rp_addr=0xC00 -> wp_addr=0x800.
- Assert that no cycle grants a read and a write to the same bank.
REQ-030 Mid-operation reset: assert rst_n=0 in the cycle after a read grant, with 2 writes buffered.
- rd_rsp_valid stays 0; wbuf_empty=1; wp_en=0.
